// File: rtl/redun_mont_pkg.sv
// Shared types for the redundant-form squaring core and its iteration loop.
// redun0_t holds a value as the unreduced sum a + b.
package redun_mont_pkg;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
  } redun0_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } sq_loop_state_t;

  function automatic logic is_ckpt(
    input logic [63:0] cnt,
    input int unsigned lg
  );
    logic [63:0] m;
    m = (64'd1 << lg) - 64'd1;
    return (lg != 0) && ((cnt & m) == 64'd0);
  endfunction

endpackage

// File: rtl/redun_mont.sv
// Two-stage squaring core: squares (a + b) and folds the product into
// two 16-bit halves; carries lost beyond bit 31 raise o_overflow.
module redun_mont
  import redun_mont_pkg::*;
(
  input  logic    i_clk,
  input  logic    i_rst,
  input  redun0_t i_sq,
  input  logic    i_val,
  output redun0_t o_mul,
  output logic    o_val,
  output logic    o_overflow
);

  logic [33:0] w_x;
  logic [33:0] w_p;
  logic [33:0] r_p;
  logic        r_v1;
  redun0_t     r_mul;
  logic        r_val;
  logic        r_ovf;

  assign w_x = 34'(i_sq.a) + 34'(i_sq.b);
  assign w_p = w_x * w_x;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_p   <= '0;
      r_v1  <= 1'b0;
      r_mul <= '0;
      r_val <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_p   <= w_p;
      r_v1  <= i_val;
      r_mul <= '{a: r_p[15:0], b: r_p[31:16]};
      r_val <= r_v1;
      r_ovf <= r_v1 && (r_p[33:32] != 2'd0);
    end
  end

  assign o_mul      = r_mul;
  assign o_val      = r_val;
  assign o_overflow = r_ovf;

endmodule

// File: rtl/redun_sq_loop.sv
// Iterated squaring engine: feeds each core result back as the next input
// for i_iter rounds, with abort, checkpoint strobes and sticky overflow.
module redun_sq_loop
  import redun_mont_pkg::*;
#(
  parameter int ITER_W  = 64,
  parameter int IN_REG  = 1,
  parameter int OUT_REG = 1,
  parameter int CKPT_LG = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  redun0_t           i_sq,
  input  logic [ITER_W-1:0] i_iter,
  input  logic              i_val,
  input  logic              i_abort,
  output logic              o_busy,
  output redun0_t           o_sq,
  output logic              o_val,
  output logic              o_ckpt,
  output logic [ITER_W-1:0] o_iter_cnt,
  output logic              o_overflow
);

  redun0_t           w_sq;
  logic [ITER_W-1:0] w_iter;
  logic              w_val;

  if (IN_REG != 0) begin : g_in
    redun0_t           r_in_sq;
    logic [ITER_W-1:0] r_in_iter;
    logic              r_in_val;
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_in_sq   <= '0;
        r_in_iter <= '0;
        r_in_val  <= 1'b0;
      end else begin
        r_in_sq   <= i_sq;
        r_in_iter <= i_iter;
        r_in_val  <= i_val;
      end
    end
    assign w_sq   = r_in_sq;
    assign w_iter = r_in_iter;
    assign w_val  = r_in_val;
  end else begin : g_in_direct
    assign w_sq   = i_sq;
    assign w_iter = i_iter;
    assign w_val  = i_val;
  end

  sq_loop_state_t    r_state;
  redun0_t           r_acc;
  logic [ITER_W-1:0] r_rem;
  logic [ITER_W-1:0] r_cnt;
  logic              r_ovf;
  logic              r_busy;
  logic              r_drop;
  logic [1:0]        r_rst_hold;
  logic              r_core_rst;
  redun0_t           r_res_sq;
  logic              r_res_val;
  logic              r_res_ckpt;

  redun0_t           w_core_mul;
  logic              w_core_raw;
  logic              w_core_ovf;
  logic              w_core_ival;
  logic              w_cres;
  logic              w_cval;
  logic [ITER_W-1:0] w_cnt_inc;
  logic              w_out_nxt;

  assign w_core_ival = (r_state == ISSUE);
  // results right after reset or from an aborted run are not ours
  assign w_cres    = w_core_raw && (r_rst_hold == 2'd0);
  assign w_cval    = w_cres && !r_drop;
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + ITER_W'(1);
  assign w_out_nxt = (OUT_REG != 0) ? r_res_val
                   : (r_state == DONE && !i_abort);

  always_ff @(posedge i_clk) begin
    r_core_rst <= i_rst;
  end

  redun_mont u_core (
    .i_clk      (i_clk),
    .i_rst      (r_core_rst),
    .i_sq       (r_acc),
    .i_val      (w_core_ival),
    .o_mul      (w_core_mul),
    .o_val      (w_core_raw),
    .o_overflow (w_core_ovf)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
      r_drop     <= 1'b0;
      r_rst_hold <= 2'd2;
      r_res_sq   <= '0;
      r_res_val  <= 1'b0;
      r_res_ckpt <= 1'b0;
    end else begin
      r_res_val  <= 1'b0;
      r_res_ckpt <= 1'b0;
      if (r_rst_hold != 2'd0) r_rst_hold <= r_rst_hold - 2'd1;
      if (w_cres) r_drop <= 1'b0;
      if (w_out_nxt) r_busy <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_val && !r_busy && !r_drop) begin
            r_acc  <= w_sq;
            r_rem  <= w_iter;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            r_busy <= 1'b1;
            r_state <= (w_iter != '0) ? ISSUE : DONE;
          end
        end
        ISSUE: begin
          if (i_abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_drop  <= 1'b1;
          end else begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (i_abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            if (!w_cval) r_drop <= 1'b1;
          end else if (w_cval) begin
            r_acc <= w_core_mul;
            r_rem <= r_rem - ITER_W'(1);
            r_cnt <= w_cnt_inc;
            r_ovf <= r_ovf | w_core_ovf;
            if (r_rem == ITER_W'(1)) begin
              r_state <= DONE;
            end else begin
              r_state <= ISSUE;
              if (is_ckpt(64'(w_cnt_inc), CKPT_LG)) begin
                r_res_sq   <= w_core_mul;
                r_res_ckpt <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          if (i_abort) begin
            r_busy <= 1'b0;
          end else begin
            r_res_sq  <= r_acc;
            r_res_val <= 1'b1;
          end
        end
      endcase
    end
  end

  assert property (@(posedge i_clk) disable iff (i_rst)
    w_cval |-> r_state == WAIT);

  if (OUT_REG != 0) begin : g_out
    redun0_t r_out_sq;
    logic    r_out_val;
    logic    r_out_ckpt;
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_out_sq   <= '0;
        r_out_val  <= 1'b0;
        r_out_ckpt <= 1'b0;
      end else begin
        if (r_res_val || r_res_ckpt) r_out_sq <= r_res_sq;
        r_out_val  <= r_res_val;
        r_out_ckpt <= r_res_ckpt;
      end
    end
    assign o_sq   = r_out_sq;
    assign o_val  = r_out_val;
    assign o_ckpt = r_out_ckpt;
  end else begin : g_out_direct
    assign o_sq   = r_res_sq;
    assign o_val  = r_res_val;
    assign o_ckpt = r_res_ckpt;
  end

  assign o_busy     = r_busy;
  assign o_iter_cnt = r_cnt;
  assign o_overflow = r_ovf;

endmodule

// File: tb/tb_redun_sq_loop.sv
// Directed bench for redun_sq_loop: latency, iteration, checkpoints,
// abort/drop, busy rejection, mid-run reset and sticky overflow.
module tb_redun_sq_loop;
  import redun_mont_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  redun0_t     i_sq;
  logic [63:0] i_iter;
  logic        i_val;
  logic        i_abort;
  logic        o_busy;
  redun0_t     o_sq;
  logic        o_val;
  logic        o_ckpt;
  logic [63:0] o_iter_cnt;
  logic        o_overflow;

  int checks = 0;
  int failures = 0;
  int n_oval = 0;
  int n_civ = 0;
  redun0_t ckq[$];

  always #5 clk = ~clk;

  redun_sq_loop #(
    .ITER_W (64),
    .IN_REG (1),
    .OUT_REG(1),
    .CKPT_LG(2)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_sq      (i_sq),
    .i_iter    (i_iter),
    .i_val     (i_val),
    .i_abort   (i_abort),
    .o_busy    (o_busy),
    .o_sq      (o_sq),
    .o_val     (o_val),
    .o_ckpt    (o_ckpt),
    .o_iter_cnt(o_iter_cnt),
    .o_overflow(o_overflow)
  );

  always @(posedge clk) begin
    if (!rst) begin
      if (o_val) n_oval++;
      if (o_ckpt) ckq.push_back(o_sq);
      if (dut.u_core.i_val) n_civ++;
    end
  end

  function automatic redun0_t sq_model(input redun0_t v);
    logic [33:0] x;
    logic [33:0] p;
    x = 34'(v.a) + 34'(v.b);
    p = x * x;
    return '{a: p[15:0], b: p[31:16]};
  endfunction

  function automatic redun0_t pow_model(input redun0_t v, input int n);
    redun0_t r;
    r = v;
    for (int k = 0; k < n; k++) r = sq_model(r);
    return r;
  endfunction

  task automatic clr_mon();
    n_oval = 0;
    n_civ = 0;
    ckq.delete();
  endtask

  task automatic start(input redun0_t sq, input logic [63:0] it);
    i_sq = sq;
    i_iter = it;
    i_val = 1'b1;
  endtask

  task automatic wait_val(input int max, output int lat, output bit ok);
    ok = 1'b0;
    lat = -1;
    for (int k = 1; k <= max && !ok; k++) begin
      @(negedge clk);
      i_val = 1'b0;
      if (o_val) begin
        ok = 1'b1;
        lat = k - 1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_sq = '0;
    i_iter = '0;
    i_val = 1'b0;
    i_abort = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_busy, o_val, o_ckpt, o_overflow} !== 4'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b want 0000",
               {o_busy, o_val, o_ckpt, o_overflow});
    end
    checks++;
    if (o_sq !== '0 || o_iter_cnt !== '0) begin
      failures++;
      $display("FAIL reset_data: got sq=%h cnt=%0d want 0", o_sq, o_iter_cnt);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_zero_iter();
    int lat;
    bit ok;
    clr_mon();
    start('{a: 16'd5, b: 16'd0}, 64'd0);
    wait_val(20, lat, ok);
    checks++;
    if (!ok || lat !== 3) begin
      failures++;
      $display("FAIL zero_latency: got %0d want 3", lat);
    end
    checks++;
    if (o_sq !== redun0_t'({16'd5, 16'd0}) || o_iter_cnt !== 64'd0) begin
      failures++;
      $display("FAIL zero_result: got sq=%h cnt=%0d want 00050000 cnt=0",
               o_sq, o_iter_cnt);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_busy: got %b want 0", o_busy);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (n_civ !== 0 || n_oval !== 1) begin
      failures++;
      $display("FAIL zero_core: got core_ival=%0d oval=%0d want 0 1",
               n_civ, n_oval);
    end
  endtask

  task automatic test_iter4();
    int lat;
    bit ok;
    clr_mon();
    start('{a: 16'd3, b: 16'd0}, 64'd4);
    wait_val(60, lat, ok);
    checks++;
    if (!ok || lat !== 15) begin
      failures++;
      $display("FAIL iter4_latency: got %0d want 15", lat);
    end
    checks++;
    if (o_sq !== redun0_t'({16'hD741, 16'h0290}) || o_iter_cnt !== 64'd4) begin
      failures++;
      $display("FAIL iter4_result: got sq=%h cnt=%0d want d7410290 cnt=4",
               o_sq, o_iter_cnt);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (n_civ !== 4 || n_oval !== 1 || ckq.size() !== 0) begin
      failures++;
      $display("FAIL iter4_counts: got ival=%0d oval=%0d ckpt=%0d want 4 1 0",
               n_civ, n_oval, ckq.size());
    end
  endtask

  task automatic test_ckpt();
    int lat;
    bit ok;
    redun0_t s3;
    s3 = '{a: 16'd3, b: 16'd0};
    clr_mon();
    start(s3, 64'd10);
    wait_val(100, lat, ok);
    checks++;
    if (!ok || lat !== 33) begin
      failures++;
      $display("FAIL ckpt_latency: got %0d want 33", lat);
    end
    checks++;
    if (o_sq !== pow_model(s3, 10) || o_iter_cnt !== 64'd10) begin
      failures++;
      $display("FAIL ckpt_final: got sq=%h cnt=%0d want %h cnt=10",
               o_sq, o_iter_cnt, pow_model(s3, 10));
    end
    repeat (4) @(negedge clk);
    checks++;
    if (ckq.size() !== 2) begin
      failures++;
      $display("FAIL ckpt_count: got %0d want 2", ckq.size());
    end else begin
      checks++;
      if (ckq[0] !== redun0_t'({16'hD741, 16'h0290})) begin
        failures++;
        $display("FAIL ckpt_4: got %h want d7410290", ckq[0]);
      end
      checks++;
      if (ckq[1] !== pow_model(s3, 8)) begin
        failures++;
        $display("FAIL ckpt_8: got %h want %h", ckq[1], pow_model(s3, 8));
      end
    end
    checks++;
    if (n_oval !== 1) begin
      failures++;
      $display("FAIL ckpt_oval: got %0d want 1", n_oval);
    end
  endtask

  task automatic test_abort();
    int lat;
    bit ok;
    bit hit;
    clr_mon();
    start('{a: 16'd3, b: 16'd0}, 64'd100);
    hit = 1'b0;
    for (int k = 0; k < 400 && !hit; k++) begin
      @(negedge clk);
      i_val = 1'b0;
      if (o_iter_cnt == 64'd37) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL abort_reach37: got cnt=%0d want 37", o_iter_cnt);
    end
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    checks++;
    if (o_busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_busy: got %b want 0", o_busy);
    end
    start('{a: 16'd3, b: 16'd0}, 64'd2);
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      @(negedge clk);
      if (o_busy) hit = 1'b1;
    end
    i_val = 1'b0;
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL abort_restart: got busy=%b want 1", o_busy);
    end
    wait_val(40, lat, ok);
    checks++;
    if (!ok || o_sq !== redun0_t'({16'd81, 16'd0}) || o_iter_cnt !== 64'd2) begin
      failures++;
      $display("FAIL abort_result: got sq=%h cnt=%0d want 00510000 cnt=2",
               o_sq, o_iter_cnt);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (n_oval !== 1) begin
      failures++;
      $display("FAIL abort_oval: got %0d want 1", n_oval);
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    bit ok;
    clr_mon();
    start('{a: 16'd3, b: 16'd0}, 64'd4);
    @(negedge clk);
    i_val = 1'b0;
    repeat (3) @(negedge clk);
    start('{a: 16'd9, b: 16'd0}, 64'd1);
    wait_val(60, lat, ok);
    checks++;
    if (!ok || o_sq !== redun0_t'({16'hD741, 16'h0290}) || o_iter_cnt !== 64'd4) begin
      failures++;
      $display("FAIL busy_result: got sq=%h cnt=%0d want d7410290 cnt=4",
               o_sq, o_iter_cnt);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (n_oval !== 1 || n_civ !== 4 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_ignored: got oval=%0d ival=%0d busy=%b want 1 4 0",
               n_oval, n_civ, o_busy);
    end
  endtask

  task automatic test_midrun_reset();
    int lat;
    bit ok;
    start('{a: 16'd3, b: 16'd0}, 64'd10);
    @(negedge clk);
    i_val = 1'b0;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_busy, o_val, o_ckpt, o_overflow} !== 4'b0 ||
        o_sq !== '0 || o_iter_cnt !== '0) begin
      failures++;
      $display("FAIL midrst_outputs: got busy=%b sq=%h cnt=%0d want all 0",
               o_busy, o_sq, o_iter_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
    clr_mon();
    start('{a: 16'd3, b: 16'd0}, 64'd1);
    wait_val(30, lat, ok);
    checks++;
    if (!ok || o_sq !== redun0_t'({16'd9, 16'd0}) || o_iter_cnt !== 64'd1) begin
      failures++;
      $display("FAIL midrst_rerun: got sq=%h cnt=%0d want 00090000 cnt=1",
               o_sq, o_iter_cnt);
    end
  endtask

  task automatic test_overflow();
    int lat;
    bit ok;
    bit hit;
    start('{a: 16'hFFFD, b: 16'h0000}, 64'd3);
    wait_val(60, lat, ok);
    checks++;
    if (!ok || o_overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set: got %b want 1", o_overflow);
    end
    checks++;
    if (o_sq !== redun0_t'({16'h00E1, 16'h0000})) begin
      failures++;
      $display("FAIL ovf_result: got %h want 00e10000", o_sq);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (o_overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_held: got %b want 1", o_overflow);
    end
    start('{a: 16'd3, b: 16'd0}, 64'd1);
    hit = 1'b0;
    for (int k = 0; k < 10 && !hit; k++) begin
      @(negedge clk);
      i_val = 1'b0;
      if (o_busy) hit = 1'b1;
    end
    checks++;
    if (!hit || o_overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear: got busy=%b ovf=%b want 1 0", o_busy, o_overflow);
    end
    wait_val(30, lat, ok);
    checks++;
    if (!ok || o_overflow !== 1'b0 || o_sq !== redun0_t'({16'd9, 16'd0})) begin
      failures++;
      $display("FAIL ovf_next_run: got sq=%h ovf=%b want 00090000 0",
               o_sq, o_overflow);
    end
  endtask

  initial begin
    test_reset();
    test_zero_iter();
    test_iter4();
    test_ckpt();
    test_abort();
    test_busy_ignore();
    test_midrun_reset();
    test_overflow();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
